// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for pipeline_ctrl: stall-hold masks, arbiter state encoding and mask merge.
package pipeline_ctrl_pkg;

  // Hold masks, bit order {mem_wb, ex_mem, id_ex, if_id, pc}
  localparam logic [4:0] STALL_MEM  = 5'b01111;
  localparam logic [4:0] STALL_LOAD = 5'b00111;
  localparam logic [4:0] STALL_IF   = 5'b00011;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_ACC  = 2'd1,
    ARB_MEM_ACC = 2'd2
  } arb_state_e;

  function automatic logic [4:0] stall_merge(input logic mem_wait,
                                             input logic load_stall,
                                             input logic if_wait);
    logic [4:0] m;
    m = 5'b00000;
    if (mem_wait)   m = m | STALL_MEM;
    if (load_stall) m = m | STALL_LOAD;
    if (if_wait)    m = m | STALL_IF;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Shared memory-port handshake between the IF/MEM stages (master) and pipeline_ctrl (slave).
interface pipeline_ctrl_if;
  // Handshake: a stage raises *_req_i and keeps it until its *_done_o pulse; *_gnt_o marks
  // the cycles the port is owned, *_done_o completes exactly one access. A req sampled high
  // on the completing edge is taken as the next access (MEM before IF). Dropping a req while
  // granted does not abort the access in flight.
  logic if_req_i;
  logic mem_req_i;
  logic if_gnt_o;
  logic mem_gnt_o;
  logic if_done_o;
  logic mem_done_o;
  logic if_discard_o;

  modport master (
    output if_req_i, mem_req_i,
    input  if_gnt_o, mem_gnt_o, if_done_o, mem_done_o, if_discard_o
  );

  modport slave (
    input  if_req_i, mem_req_i,
    output if_gnt_o, mem_gnt_o, if_done_o, mem_done_o, if_discard_o
  );
endinterface

// File: rtl/pipeline_ctrl_mem_port_arbiter.sv
// Single memory port arbiter: MEM-priority FSM with fixed MEM_LAT access length.
module mem_port_arbiter
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req_i,
  input  logic       mem_req_i,
  output logic       if_gnt_o,
  output logic       mem_gnt_o,
  output logic       if_done_o,
  output logic       mem_done_o,
  output arb_state_e state_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_beat;

  assign last_beat = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (mem_req_i)     state_d = ARB_MEM_ACC;
        else if (if_req_i) state_d = ARB_IF_ACC;
      end
      ARB_IF_ACC, ARB_MEM_ACC: begin
        if (last_beat) begin
          // Re-arbitrate on the completing edge so back-to-back accesses have no bubble
          cnt_d = '0;
          if (mem_req_i)     state_d = ARB_MEM_ACC;
          else if (if_req_i) state_d = ARB_IF_ACC;
          else               state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_gnt_o   = (state_q == ARB_IF_ACC);
  assign mem_gnt_o  = (state_q == ARB_MEM_ACC);
  assign if_done_o  = if_gnt_o && last_beat;
  assign mem_done_o = mem_gnt_o && last_beat;
  assign state_o    = state_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load scoreboard, stall merge,
// IF/ID flush and memory-port arbitration. Define PIPELINE_CTRL_PERF_EN for stall counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int NREG    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid_i,
  input  logic                 id_r1_read_i,
  input  logic [4:0]           id_r1_addr_i,
  input  logic                 id_r2_read_i,
  input  logic [4:0]           id_r2_addr_i,
  input  logic                 id_is_load_i,
  input  logic [4:0]           id_wd_i,
  input  logic                 id_jump_i,
  input  logic                 wb_i,
  input  logic [4:0]           wb_addr_i,
  pipeline_ctrl_if.slave       mem_if,
  output logic [4:0]           stall_o,
  output logic                 flush_o,
  output logic                 load_stall_o,
  output arb_state_e           arb_state_o
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_load_cnt_o,
  output logic [31:0]          perf_mem_cnt_o
`endif
);

  logic [NREG-1:0] sb_q, sb_d;
  logic            discard_q, discard_d;
  logic            r1_haz, r2_haz, sb_set, mem_wait, if_wait;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (mem_if.if_req_i),
    .mem_req_i  (mem_if.mem_req_i),
    .if_gnt_o   (mem_if.if_gnt_o),
    .mem_gnt_o  (mem_if.mem_gnt_o),
    .if_done_o  (mem_if.if_done_o),
    .mem_done_o (mem_if.mem_done_o),
    .state_o    (arb_state_o)
  );

  // Regfile is write-through, so a same-cycle WB of the source clears the hazard
  assign r1_haz = id_r1_read_i && (id_r1_addr_i != 5'd0) && sb_q[id_r1_addr_i]
                  && !(wb_i && (wb_addr_i == id_r1_addr_i));
  assign r2_haz = id_r2_read_i && (id_r2_addr_i != 5'd0) && sb_q[id_r2_addr_i]
                  && !(wb_i && (wb_addr_i == id_r2_addr_i));
  assign load_stall_o = id_valid_i && (r1_haz || r2_haz);

  assign mem_wait = mem_if.mem_req_i && !mem_if.mem_done_o;
  assign if_wait  = mem_if.if_req_i && !mem_if.if_done_o;
  assign stall_o  = stall_merge(mem_wait, load_stall_o, if_wait);
  assign flush_o  = id_jump_i && !stall_o[2];

  assign sb_set = id_valid_i && id_is_load_i && (id_wd_i != 5'd0) && !stall_o[2];

  always_comb begin
    sb_d = sb_q;
    if (wb_i)   sb_d[wb_addr_i] = 1'b0;
    if (sb_set) sb_d[id_wd_i]   = 1'b1;
  end

  // A flush mid-fetch marks the word in flight as stale until its done pulse
  always_comb begin
    discard_d = discard_q;
    if (mem_if.if_done_o)                           discard_d = 1'b0;
    else if (flush_o && arb_state_o == ARB_IF_ACC)  discard_d = 1'b1;
  end

  assign mem_if.if_discard_o = mem_if.if_done_o && (discard_q || flush_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      discard_q <= discard_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_load_q, perf_load_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  always_comb begin
    perf_load_d = perf_load_q + {31'd0, load_stall_o};
    perf_mem_d  = perf_mem_q + {31'd0, mem_wait};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_q <= '0;
      perf_mem_q  <= '0;
    end else begin
      perf_load_q <= perf_load_d;
      perf_mem_q  <= perf_mem_d;
    end
  end

  assign perf_load_cnt_o = perf_load_q;
  assign perf_mem_cnt_o  = perf_mem_q;
`endif

endmodule
